// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcode encodings, default widths and the RS entry layout.
package tomasulo_pkg;
    localparam int TAG_W_DEF  = 3;
    localparam int DATA_W_DEF = 16;

    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b0001;
    localparam logic [3:0] FN_MUL = 4'b0010;
    localparam logic [3:0] FN_DIV = 4'b0011;
    localparam logic [3:0] FN_LD  = 4'b0100;
    localparam logic [3:0] FN_ST  = 4'b0101;
    localparam logic [3:0] FN_BEQ = 4'b0110;
    localparam logic [3:0] FN_BNE = 4'b0111;

    // Default-width entry; the scheduler re-declares this shape with its own widths.
    typedef struct packed {
        logic                  rdy;
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] val;
    } rs_src_t;

    typedef struct packed {
        logic                 valid;
        logic [3:0]           func;
        logic [TAG_W_DEF-1:0] rob;
        rs_src_t              s1;
        rs_src_t              s2;
    } rs_entry_t;
endpackage

// File: rtl/rs_issue_sched_if.sv
// Dispatch / CDB / functional-unit signals of one reservation station.
interface rs_issue_sched_if #(
    parameter int DATA_W = tomasulo_pkg::DATA_W_DEF,
    parameter int TAG_W  = tomasulo_pkg::TAG_W_DEF
) ();
    logic              alloc_valid;
    logic              alloc_ready;
    logic [3:0]        alloc_func;
    logic [TAG_W-1:0]  alloc_rob;
    logic              alloc_s1_rdy, alloc_s2_rdy;
    logic [TAG_W-1:0]  alloc_s1_tag, alloc_s2_tag;
    logic [DATA_W-1:0] alloc_s1_val, alloc_s2_val;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              issue_valid;
    logic              issue_ready;
    logic [3:0]        issue_func;
    logic [TAG_W-1:0]  issue_rob;
    logic [DATA_W-1:0] issue_op1, issue_op2;

    modport master (
        output alloc_valid, alloc_func, alloc_rob, alloc_s1_rdy, alloc_s2_rdy,
               alloc_s1_tag, alloc_s2_tag, alloc_s1_val, alloc_s2_val,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  alloc_ready, issue_valid, issue_func, issue_rob, issue_op1, issue_op2
    );

    modport slave (
        input  alloc_valid, alloc_func, alloc_rob, alloc_s1_rdy, alloc_s2_rdy,
               alloc_s1_tag, alloc_s2_tag, alloc_s1_val, alloc_s2_val,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        output alloc_ready, issue_valid, issue_func, issue_rob, issue_op1, issue_op2
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request at or after ptr, wrapping; one-hot grant plus index.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/rs_issue_sched.sv
// Reservation-station scheduler: allocate, CDB wakeup, round-robin issue.
// Define RS_CDB_BYPASS_EN to capture a matching CDB broadcast during allocation instead of stalling dispatch.
module rs_issue_sched
    import tomasulo_pkg::*;
#(
    parameter int ENTRIES = 3,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    rs_issue_sched_if.slave              bus,
    output logic [$clog2(ENTRIES+1)-1:0] occupancy
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int OCC_W = $clog2(ENTRIES+1);

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } src_t;

    typedef struct packed {
        logic [3:0]       func;
        logic [TAG_W-1:0] rob;
        src_t             s1;
        src_t             s2;
    } ent_t;

    logic [ENTRIES-1:0] valid, cand, gnt;
    ent_t               ent [ENTRIES];
    logic [IDX_W-1:0]   rr, gnt_idx, free_idx;
    logic               any_free, any_cand, alloc_fire, issue_fire, cdb_stall;
    logic               cdb_v;
    logic [TAG_W-1:0]   cdb_t;
    logic [DATA_W-1:0]  cdb_d;
    src_t               a1, a2, a1_in, a2_in;

    assign cdb_v = bus.cdb_valid;
    assign cdb_t = bus.cdb_tag;
    assign cdb_d = bus.cdb_data;

    function automatic src_t snoop(src_t s);
        src_t r;
        r = s;
        if (!s.rdy && cdb_v && s.tag == cdb_t) begin
            r.rdy = 1'b1;
            r.val = cdb_d;
        end
        return r;
    endfunction

    assign a1 = {bus.alloc_s1_rdy, bus.alloc_s1_tag, bus.alloc_s1_val};
    assign a2 = {bus.alloc_s2_rdy, bus.alloc_s2_tag, bus.alloc_s2_val};

`ifdef RS_CDB_BYPASS_EN
    assign cdb_stall = 1'b0;
    assign a1_in     = snoop(a1);
    assign a2_in     = snoop(a2);
`else
    // No capture path on the allocation port, so dispatch waits out every broadcast.
    assign cdb_stall = cdb_v;
    assign a1_in     = a1;
    assign a2_in     = a2;
`endif

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES-1; i >= 0; i--) begin
            if (!valid[i]) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_cand
        assign cand[i] = valid[i] & ent[i].s1.rdy & ent[i].s2.rdy;
    end

    rr_arbiter #(.N(ENTRIES)) u_arb (
        .req (cand),
        .ptr (rr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (any_cand)
    );

    assign bus.alloc_ready = any_free & ~flush & ~cdb_stall;
    assign bus.issue_valid = any_cand & ~flush;
    assign alloc_fire      = bus.alloc_valid & bus.alloc_ready;
    assign issue_fire      = bus.issue_valid & bus.issue_ready;

    always_comb begin
        bus.issue_func = '0;
        bus.issue_rob  = '0;
        bus.issue_op1  = '0;
        bus.issue_op2  = '0;
        if (bus.issue_valid) begin
            bus.issue_func = ent[gnt_idx].func;
            bus.issue_rob  = ent[gnt_idx].rob;
            bus.issue_op1  = ent[gnt_idx].s1.val;
            bus.issue_op2  = ent[gnt_idx].s2.val;
        end
    end

    // A freed slot reads as valid to the free search until the edge, so it is not reused the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (alloc_fire && free_idx == IDX_W'(i)) begin
                    valid[i]    <= 1'b1;
                    ent[i].func <= bus.alloc_func;
                    ent[i].rob  <= bus.alloc_rob;
                    ent[i].s1   <= a1_in;
                    ent[i].s2   <= a2_in;
                end else if (issue_fire && gnt[i]) begin
                    valid[i] <= 1'b0;
                end else if (valid[i]) begin
                    ent[i].s1 <= snoop(ent[i].s1);
                    ent[i].s2 <= snoop(ent[i].s2);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr        <= '0;
            occupancy <= '0;
        end else if (flush) begin
            rr        <= '0;
            occupancy <= '0;
        end else begin
            if (issue_fire)
                rr <= (gnt_idx == IDX_W'(ENTRIES-1)) ? '0 : gnt_idx + 1'b1;
            occupancy <= occupancy + OCC_W'(alloc_fire) - OCC_W'(issue_fire);
        end
    end
endmodule
